// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Registered instruction-decode stage of the 16-bit pipelined core. Decodes
//   one instruction per cycle, reads the register file combinationally,
//   resolves BEQ/BNE/B using flagZ, squashes the wrong-path fetch after a
//   taken branch and drives a valid-tagged ID/EX pipeline register.
//
// Build option:
//   ID_LOAD_USE_DETECT_EN  defined   -> internal load-use hazard detection
//                          undefined -> only ex_stall / hazard_detected stall
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_valid, instruction, pc_in   instruction handed over by IF
//   flagZ                 zero flag used to resolve BEQ/BNE
//   ex_stall              EX cannot accept: hold the whole ID/EX register
//   hazard_detected       external hazard: insert a bubble
//   rf_raddr1/2, rf_rdata1/2       register-file read port (same cycle)
//   id_stall              IF must hold PC and instruction
//   br_taken, br_target   branch redirect to IF
//   ex_*                  registered ID/EX pipeline outputs
// -----------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4,
  parameter int PC_LEN       = 16,
  parameter int EXE_CMD_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [15:0]             instruction,
  input  logic [PC_LEN-1:0]       pc_in,
  input  logic                    flagZ,
  input  logic                    ex_stall,
  input  logic                    hazard_detected,
  output logic [REG_ADDR_LEN-1:0] rf_raddr1,
  output logic [REG_ADDR_LEN-1:0] rf_raddr2,
  input  logic [WORD_LEN-1:0]     rf_rdata1,
  input  logic [WORD_LEN-1:0]     rf_rdata2,
  output logic                    id_stall,
  output logic                    br_taken,
  output logic [PC_LEN-1:0]       br_target,
  output logic                    ex_valid,
  output logic                    ex_mem_r_en,
  output logic                    ex_mem_w_en,
  output logic                    ex_wb_en,
  output logic                    ex_is_imm,
  output logic                    ex_st,
  output logic [EXE_CMD_LEN-1:0]  ex_exe_cmd,
  output logic [REG_ADDR_LEN-1:0] ex_dest,
  output logic [REG_ADDR_LEN-1:0] ex_src1,
  output logic [REG_ADDR_LEN-1:0] ex_src2,
  output logic [WORD_LEN-1:0]     ex_val1,
  output logic [WORD_LEN-1:0]     ex_val2,
  output logic [WORD_LEN-1:0]     ex_imm,
  output logic [PC_LEN-1:0]       ex_pc
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_SHL  = 4'h4, OP_CMP = 4'h5, OP_MOVI = 4'h6, OP_MOVR = 4'h7,
    OP_BEQ  = 4'h8, OP_BNE = 4'h9, OP_B   = 4'hA,
    OP_LDR  = 4'hC, OP_STR = 4'hD
  } opcode_e;

  localparam logic [EXE_CMD_LEN-1:0] CMD_NOP = EXE_CMD_LEN'(15);

  typedef struct packed {
    logic                    valid;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
    logic                    is_imm;
    logic                    st;
    logic [EXE_CMD_LEN-1:0]  exe_cmd;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [WORD_LEN-1:0]     val1;
    logic [WORD_LEN-1:0]     val2;
    logic [WORD_LEN-1:0]     imm;
    logic [PC_LEN-1:0]       pc;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    kill_q, kill_d;

  logic [3:0]              opcode;
  logic [EXE_CMD_LEN-1:0]  dec_cmd;
  logic                    dec_mem_r, dec_mem_w, dec_wb, dec_is_imm, dec_st;
  logic                    is_beq, is_bne, is_b, is_mem;
  logic [REG_ADDR_LEN-1:0] dest_f, src1_f, src2_f;
  logic [WORD_LEN-1:0]     imm_f;
  logic                    ld_hz, issue_valid;

  assign opcode = instruction[15:12];

  // Instruction decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    dec_cmd    = CMD_NOP;
    dec_mem_r  = 1'b0;
    dec_mem_w  = 1'b0;
    dec_wb     = 1'b0;
    dec_is_imm = 1'b0;
    dec_st     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_b       = 1'b0;
    case (opcode)
      OP_ADD:  begin dec_cmd = EXE_CMD_LEN'(0); dec_wb = 1'b1; end
      OP_SUB:  begin dec_cmd = EXE_CMD_LEN'(1); dec_wb = 1'b1; end
      OP_AND:  begin dec_cmd = EXE_CMD_LEN'(2); dec_wb = 1'b1; end
      OP_OR:   begin dec_cmd = EXE_CMD_LEN'(3); dec_wb = 1'b1; end
      OP_SHL:  begin dec_cmd = EXE_CMD_LEN'(4); dec_wb = 1'b1; end
      OP_CMP:  dec_cmd = EXE_CMD_LEN'(1);
      OP_MOVI: begin dec_cmd = EXE_CMD_LEN'(5); dec_wb = 1'b1; dec_is_imm = 1'b1; end
      OP_MOVR: begin dec_cmd = EXE_CMD_LEN'(5); dec_wb = 1'b1; end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_B:    is_b = 1'b1;
      OP_LDR:  begin
        dec_cmd = EXE_CMD_LEN'(0); dec_is_imm = 1'b1; dec_mem_r = 1'b1; dec_wb = 1'b1;
      end
      OP_STR:  begin
        dec_cmd = EXE_CMD_LEN'(0); dec_is_imm = 1'b1; dec_mem_w = 1'b1; dec_st = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory ops carry a 4-bit offset; everything else an 8-bit immediate.
  // STR reads its store data register from the dest field.
  assign is_mem = (opcode == OP_LDR) || (opcode == OP_STR);
  assign dest_f = REG_ADDR_LEN'(instruction[11:8]);
  assign src1_f = REG_ADDR_LEN'(instruction[7:4]);
  assign src2_f = (opcode == OP_STR) ? REG_ADDR_LEN'(instruction[11:8])
                                     : REG_ADDR_LEN'(instruction[3:0]);
  assign imm_f  = is_mem ? WORD_LEN'(instruction[3:0]) : WORD_LEN'(instruction[7:0]);

  assign rf_raddr1 = src1_f;
  assign rf_raddr2 = src2_f;

`ifdef ID_LOAD_USE_DETECT_EN
  logic use_src1, use_src2;

  always_comb begin
    use_src1 = 1'b0;
    use_src2 = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_CMP, OP_STR: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
      end
      OP_MOVR, OP_LDR: use_src1 = 1'b1;
      default: ;
    endcase
  end

  // A load in EX has not produced its data yet; a dependent instruction waits one cycle.
  assign ld_hz = ex_q.valid & ex_q.mem_r_en & if_valid & ~kill_q &
                 ((use_src1 & (src1_f == ex_q.dest)) | (use_src2 & (src2_f == ex_q.dest)));
`else
  assign ld_hz = 1'b0;
`endif

  assign id_stall    = ex_stall | hazard_detected | ld_hz;
  assign issue_valid = if_valid & ~kill_q;
  assign br_taken    = issue_valid & ~id_stall & (is_b | (is_beq & flagZ) | (is_bne & ~flagZ));
  assign br_target   = pc_in + PC_LEN'($signed(instruction[11:0]));

  // Next state of the ID/EX register and the wrong-path kill flag.
  always_comb begin
    ex_d   = ex_q;
    kill_d = kill_q;
    if (!ex_stall) begin
      // The slot after a taken branch is squashed; kill drops once a valid
      // instruction has actually been consumed as that bubble.
      if (br_taken)                   kill_d = 1'b1;
      else if (if_valid && !id_stall) kill_d = 1'b0;

      if (hazard_detected || ld_hz) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = issue_valid;
        ex_d.mem_r_en = issue_valid & dec_mem_r;
        ex_d.mem_w_en = issue_valid & dec_mem_w;
        ex_d.wb_en    = issue_valid & dec_wb;
        ex_d.is_imm   = issue_valid & dec_is_imm;
        ex_d.st       = issue_valid & dec_st;
        ex_d.exe_cmd  = issue_valid ? dec_cmd : CMD_NOP;
        ex_d.dest     = dest_f;
        ex_d.src1     = src1_f;
        ex_d.src2     = src2_f;
        ex_d.val1     = rf_rdata1;
        ex_d.val2     = rf_rdata2;
        ex_d.imm      = imm_f;
        ex_d.pc       = pc_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ex_q   <= '0;
      kill_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      kill_q <= kill_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_mem_r_en = ex_q.mem_r_en;
  assign ex_mem_w_en = ex_q.mem_w_en;
  assign ex_wb_en    = ex_q.wb_en;
  assign ex_is_imm   = ex_q.is_imm;
  assign ex_st       = ex_q.st;
  assign ex_exe_cmd  = ex_q.exe_cmd;
  assign ex_dest     = ex_q.dest;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign ex_val1     = ex_q.val1;
  assign ex_val2     = ex_q.val2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//   Directed bench for id_stage_pipe. Each stimulus cycle pushes the expected
//   ID/EX contents for the following edge into a queue; an independent monitor
//   pops one entry after every rising edge and compares it with the outputs.
//   Combinational outputs (br_taken, id_stall, br_target, rf_raddr) are checked
//   while the inputs are applied.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] instruction;
  logic [15:0] pc_in;
  logic        flagZ;
  logic        ex_stall;
  logic        hazard_detected;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        id_stall, br_taken;
  logic [15:0] br_target;
  logic        ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st;
  logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
  logic [15:0] ex_val1, ex_val2, ex_imm, ex_pc;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid        (if_valid),
    .instruction     (instruction),
    .pc_in           (pc_in),
    .flagZ           (flagZ),
    .ex_stall        (ex_stall),
    .hazard_detected (hazard_detected),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .id_stall        (id_stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .ex_valid        (ex_valid),
    .ex_mem_r_en     (ex_mem_r_en),
    .ex_mem_w_en     (ex_mem_w_en),
    .ex_wb_en        (ex_wb_en),
    .ex_is_imm       (ex_is_imm),
    .ex_st           (ex_st),
    .ex_exe_cmd      (ex_exe_cmd),
    .ex_dest         (ex_dest),
    .ex_src1         (ex_src1),
    .ex_src2         (ex_src2),
    .ex_val1         (ex_val1),
    .ex_val2         (ex_val2),
    .ex_imm          (ex_imm),
    .ex_pc           (ex_pc)
  );

  // chk_data = 0 means only the valid bit and enables are defined (squashed slot).
  typedef struct packed {
    logic        chk_data;
    logic        valid, mem_r, mem_w, wb, is_imm, st;
    logic [3:0]  cmd, dest, src1, src2;
    logic [15:0] val1, val2, imm, pc;
  } exp_t;

  // Flag sets, ordered {mem_r, mem_w, wb, is_imm, st}.
  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_WB    = 5'b00100;
  localparam logic [4:0] F_IMMWB = 5'b00110;
  localparam logic [4:0] F_LDR   = 5'b10110;
  localparam logic [4:0] F_STR   = 5'b01011;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  exp_t bub, kil, e_add, e_str, e_a74, e_b80;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] fl, input logic [3:0] cmd, input logic [3:0] dest,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] imm, input logic [15:0] pc);
    exp_t r;
    r          = '0;
    r.chk_data = 1'b1;
    r.valid    = 1'b1;
    {r.mem_r, r.mem_w, r.wb, r.is_imm, r.st} = fl;
    r.cmd  = cmd;
    r.dest = dest;
    r.src1 = s1;
    r.src2 = s2;
    r.val1 = v1;
    r.val2 = v2;
    r.imm  = imm;
    r.pc   = pc;
    return r;
  endfunction

  // Apply one cycle of inputs, check the combinational outputs, queue the
  // expected ID/EX contents after the coming edge.
  task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic z, input logic exs, input logic hz, input logic [15:0] d1,
                      input logic [15:0] d2, input exp_t e, input logic exp_br, input logic exp_stall);
    @(negedge clk);
    rst             = r;
    if_valid        = v;
    instruction     = ins;
    pc_in           = pc;
    flagZ           = z;
    ex_stall        = exs;
    hazard_detected = hz;
    rf_rdata1       = d1;
    rf_rdata2       = d2;
    #1;
    check("br_taken", 128'(br_taken), 128'(exp_br));
    check("id_stall", 128'(id_stall), 128'(exp_stall));
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per rising edge that had stimulus queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ex_ctrl", 128'({ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st}),
              128'({e.valid, e.mem_r, e.mem_w, e.wb, e.is_imm, e.st}));
        if (e.chk_data)
          check("ex_data", 128'({ex_exe_cmd, ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_imm, ex_pc}),
                128'({e.cmd, e.dest, e.src1, e.src2, e.val1, e.val2, e.imm, e.pc}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; instruction = '0; pc_in = '0; flagZ = 1'b0;
    ex_stall = 1'b0; hazard_detected = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;

    bub          = '0;
    bub.chk_data = 1'b1;
    kil          = '0;

    // Reset state.
    step(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0, 16'h0, bub, 0, 0);
    step(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0, 16'h0, bub, 0, 0);

    // ADD r0, r9, r3 with register data 5 / 7.
    e_add = mk(F_WB, 4'd0, 4'h0, 4'h9, 4'h3, 16'd5, 16'd7, 16'h0093, 16'h0000);
    step(0, 1, 16'h0093, 16'h0000, 0, 0, 0, 16'd5, 16'd7, e_add, 0, 0);
    check("rf_raddr1_add", 128'(rf_raddr1), 128'(4'h9));
    check("rf_raddr2_add", 128'(rf_raddr2), 128'(4'h3));
    // MOVI and CMP.
    step(0, 1, 16'h6093, 16'h0002, 0, 0, 0, 16'd1, 16'd2,
         mk(F_IMMWB, 4'd5, 4'h0, 4'h9, 4'h3, 16'd1, 16'd2, 16'h0093, 16'h0002), 0, 0);
    step(0, 1, 16'h5093, 16'h0004, 0, 0, 0, 16'd3, 16'd3,
         mk(F_NONE, 4'd1, 4'h0, 4'h9, 4'h3, 16'd3, 16'd3, 16'h0093, 16'h0004), 0, 0);

    // BEQ taken, following ADD squashed.
    step(0, 1, 16'h8004, 16'h0010, 1, 0, 0, 16'd0, 16'd0,
         mk(F_NONE, 4'd15, 4'h0, 4'h0, 4'h4, 16'd0, 16'd0, 16'h0004, 16'h0010), 1, 0);
    check("br_target_beq", 128'(br_target), 128'(16'h0014));
    step(0, 1, 16'h0093, 16'h0012, 1, 0, 0, 16'd5, 16'd7, kil, 0, 0);

    // BEQ not taken, following ADD issues.
    step(0, 1, 16'h8004, 16'h0020, 0, 0, 0, 16'd0, 16'd0,
         mk(F_NONE, 4'd15, 4'h0, 4'h0, 4'h4, 16'd0, 16'd0, 16'h0004, 16'h0020), 0, 0);
    step(0, 1, 16'h0093, 16'h0022, 0, 0, 0, 16'd5, 16'd7,
         mk(F_WB, 4'd0, 4'h0, 4'h9, 4'h3, 16'd5, 16'd7, 16'h0093, 16'h0022), 0, 0);

    // BNE taken backwards; an idle cycle keeps kill, the next valid slot is squashed.
    step(0, 1, 16'h9FFC, 16'h0040, 0, 0, 0, 16'd0, 16'd0,
         mk(F_NONE, 4'd15, 4'hF, 4'hF, 4'hC, 16'd0, 16'd0, 16'h00FC, 16'h0040), 1, 0);
    check("br_target_bne", 128'(br_target), 128'(16'h003C));
    step(0, 0, 16'h0000, 16'h0042, 0, 0, 0, 16'd0, 16'd0, kil, 0, 0);
    step(0, 1, 16'h0093, 16'h0042, 0, 0, 0, 16'd5, 16'd7, kil, 0, 0);
    step(0, 1, 16'h1456, 16'h0044, 0, 0, 0, 16'd10, 16'd4,
         mk(F_WB, 4'd1, 4'h4, 4'h5, 4'h6, 16'd10, 16'd4, 16'h0056, 16'h0044), 0, 0);

    // LDR r2 then dependent ADD r1, r2, r3.
    step(0, 1, 16'hC210, 16'h0050, 0, 0, 0, 16'h0100, 16'h0000,
         mk(F_LDR, 4'd0, 4'h2, 4'h1, 4'h0, 16'h0100, 16'h0000, 16'h0000, 16'h0050), 0, 0);
    e_add = mk(F_WB, 4'd0, 4'h1, 4'h2, 4'h3, 16'd9, 16'd8, 16'h0023, 16'h0052);
`ifdef ID_LOAD_USE_DETECT_EN
    step(0, 1, 16'h0123, 16'h0052, 0, 0, 0, 16'd9, 16'd8, bub, 0, 1);
    step(0, 1, 16'h0123, 16'h0052, 0, 0, 0, 16'd9, 16'd8, e_add, 0, 0);
`else
    step(0, 1, 16'h0123, 16'h0052, 0, 0, 0, 16'd9, 16'd8, e_add, 0, 0);
`endif

    // STR r3 -> [r1 + 0], then EX stalls for three cycles.
    e_str = mk(F_STR, 4'd0, 4'h3, 4'h1, 4'h3, 16'h0200, 16'h0077, 16'h0000, 16'h0060);
    step(0, 1, 16'hD310, 16'h0060, 0, 0, 0, 16'h0200, 16'h0077, e_str, 0, 0);
    check("rf_raddr1_str", 128'(rf_raddr1), 128'(4'h1));
    check("rf_raddr2_str", 128'(rf_raddr2), 128'(4'h3));
    for (int i = 0; i < 3; i++)
      step(0, 1, 16'h2345, 16'h0062, 0, 1, 0, 16'h00F0, 16'h003C, e_str, 0, 1);
    step(0, 1, 16'h2345, 16'h0062, 0, 0, 0, 16'h00F0, 16'h003C,
         mk(F_WB, 4'd2, 4'h3, 4'h4, 4'h5, 16'h00F0, 16'h003C, 16'h0045, 16'h0062), 0, 0);

    // External hazard gives exactly one bubble.
    step(0, 1, 16'h3678, 16'h0064, 0, 0, 1, 16'd1, 16'd2, bub, 0, 1);
    step(0, 1, 16'h3678, 16'h0064, 0, 0, 0, 16'd1, 16'd2,
         mk(F_WB, 4'd3, 4'h6, 4'h7, 4'h8, 16'd1, 16'd2, 16'h0078, 16'h0064), 0, 0);

    // MOVR, SHL and an unassigned opcode (NOP).
    step(0, 1, 16'h7A50, 16'h0066, 0, 0, 0, 16'h1234, 16'h0000,
         mk(F_WB, 4'd5, 4'hA, 4'h5, 4'h0, 16'h1234, 16'h0000, 16'h0050, 16'h0066), 0, 0);
    step(0, 1, 16'h4111, 16'h0068, 0, 0, 0, 16'd3, 16'd1,
         mk(F_WB, 4'd4, 4'h1, 4'h1, 4'h1, 16'd3, 16'd1, 16'h0011, 16'h0068), 0, 0);
    step(0, 1, 16'hB123, 16'h006A, 0, 0, 0, 16'd0, 16'd0,
         mk(F_NONE, 4'd15, 4'h1, 4'h2, 4'h3, 16'd0, 16'd0, 16'h0023, 16'h006A), 0, 0);

    // Reset while kill is pending: next instruction is not squashed.
    step(0, 1, 16'hA002, 16'h0070, 0, 0, 0, 16'd0, 16'd0,
         mk(F_NONE, 4'd15, 4'h0, 4'h0, 4'h2, 16'd0, 16'd0, 16'h0002, 16'h0070), 1, 0);
    check("br_target_b", 128'(br_target), 128'(16'h0072));
    step(1, 1, 16'h0093, 16'h0072, 0, 0, 0, 16'd5, 16'd7, bub, 0, 0);
    e_a74 = mk(F_WB, 4'd0, 4'h0, 4'h9, 4'h3, 16'd5, 16'd7, 16'h0093, 16'h0074);
    step(0, 1, 16'h0093, 16'h0074, 0, 0, 0, 16'd5, 16'd7, e_a74, 0, 0);

    // Reset during a held stall.
    step(0, 1, 16'h1456, 16'h0076, 0, 1, 0, 16'd10, 16'd4, e_a74, 0, 1);
    step(1, 1, 16'h1456, 16'h0076, 0, 1, 0, 16'd10, 16'd4, bub, 0, 1);
    step(0, 1, 16'h1456, 16'h0076, 0, 0, 0, 16'd10, 16'd4,
         mk(F_WB, 4'd1, 4'h4, 4'h5, 4'h6, 16'd10, 16'd4, 16'h0056, 16'h0076), 0, 0);

    // Kill survives an EX stall and squashes the slot after release.
    e_b80 = mk(F_NONE, 4'd15, 4'h0, 4'h0, 4'h2, 16'd0, 16'd0, 16'h0002, 16'h0080);
    step(0, 1, 16'hA002, 16'h0080, 0, 0, 0, 16'd0, 16'd0, e_b80, 1, 0);
    step(0, 1, 16'h0093, 16'h0082, 0, 1, 0, 16'd5, 16'd7, e_b80, 0, 1);
    step(0, 1, 16'h0093, 16'h0082, 0, 0, 0, 16'd5, 16'd7, kil, 0, 0);
    step(0, 1, 16'h0093, 16'h0084, 0, 0, 0, 16'd5, 16'd7,
         mk(F_WB, 4'd0, 4'h0, 4'h9, 4'h3, 16'd5, 16'd7, 16'h0093, 16'h0084), 0, 0);
    step(0, 0, 16'h0000, 16'h0086, 0, 0, 0, 16'd0, 16'd0, kil, 0, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered decode stage for the 16-bit pipelined core, generalised in data and register-address width.
- Decodes one instruction per cycle, reads the register file and resolves BEQ/BNE/B in ID using flagZ.
- Detects load-use hazards and kills the wrong-path fetch after a taken branch.
- Drives a valid-tagged ID/EX pipeline register with stall and bubble control. Sits between IF and EX.

Parameters:
- WORD_LEN, 16, datapath width of register values, immediates, val1/val2.
- REG_ADDR_LEN, 4, register index width; instruction fields are zero-extended to this width.
- PC_LEN, 16, program counter width.
- EXE_CMD_LEN, 4, ALU command width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_valid  in  1  instruction from IF is valid.
- instruction  in  16  fetched instruction.
- pc_in  in  PC_LEN  PC of instruction.
- flagZ  in  1  zero flag from EX/status register.
- ex_stall  in  1  EX cannot accept; hold the entire ID/EX register.
- hazard_detected  in  1  external hazard; inject a bubble.
- rf_raddr1, rf_raddr2  out  REG_ADDR_LEN  combinational register-file read addresses.
- rf_rdata1, rf_rdata2  in  WORD_LEN  register-file read data, same cycle.
- id_stall  out  1  IF must hold PC and instruction.
- br_taken  out  1  combinational taken-branch to IF.
- br_target  out  PC_LEN  pc_in + sign-extended instr[11:0].
- ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st  out  1  registered controls.
- ex_exe_cmd  out  EXE_CMD_LEN  registered ALU command.
- ex_dest, ex_src1, ex_src2  out  REG_ADDR_LEN  registered register indices.
- ex_val1, ex_val2, ex_imm  out  WORD_LEN  registered operands.
- ex_pc  out  PC_LEN  registered PC.

Behaviour:
- Fields:
  - opcode = instr[15:12], dest = [11:8], src1 = [7:4], src2 = [3:0].
  - imm8 = [7:0], zero-extended.
  - LDR/STR offset = [3:0], zero-extended.
- Opcodes, with EXE_CMD and flags:
  - 0000 ADD: cmd 0, wb.
  - 0001 SUB: cmd 1, wb.
  - 0010 AND: cmd 2, wb.
  - 0011 OR: cmd 3, wb.
  - 0100 SHL: cmd 4, wb.
  - 0101 CMP: cmd 1, no wb.
  - 0110 MOVI: cmd 5, is_imm, wb, uses no src.
  - 0111 MOVR: cmd 5, wb, uses src1 only.
  - 1000 BEQ, 1001 BNE, 1010 B: cmd 15, no wb, use no src.
  - 1100 LDR: cmd 0, is_imm, mem_r, wb, uses src1.
  - 1101 STR: cmd 0, is_imm, mem_w, st, src1 = base, src2 = [11:8] (data), no wb.
  - All other opcodes: NOP (cmd 15, all enables 0).
- rf_raddr1 = src1, rf_raddr2 = src2 (STR: [11:8]). val1 = rf_rdata1, val2 = rf_rdata2.
- kill register:
  - Set on the cycle br_taken = 1 and ID/EX advances.
  - Next valid ID instruction is treated as a NOP bubble (ex_valid = 0), then kill clears.
  - kill is held while ex_stall = 1.
- br_taken = if_valid & ~kill & ~id_stall & (B | BEQ & flagZ | BNE & ~flagZ).
- Load-use stall (ld_hz) when all of:
  - ex_valid & ex_mem_r_en;
  - if_valid & ~kill;
  - current instruction uses a source equal to ex_dest.
- id_stall = ex_stall | hazard_detected | ld_hz.
- Priority per cycle, highest first:
  - rst: all ex_* = 0, kill = 0.
  - ex_stall: every ex_* register holds; kill holds.
  - hazard_detected | ld_hz: bubble (ex_valid = 0, all enables 0; data fields don't-care, driven 0).
  - Otherwise: load decoded fields; ex_valid = if_valid & ~kill.
- Latency: 1 cycle from instruction to ex_*. Throughput 1/cycle absent stalls.
- Reset mid-stall or mid-kill: all state cleared next edge; no held instruction survives.
- if_valid = 0: bubble, kill unchanged.

Optional Feature:
- Macro ID_LOAD_USE_DETECT_EN.
- Defined: internal ld_hz logic as above.
- Undefined: ld_hz tied to 0; only hazard_detected and ex_stall cause stalls. Decode, branch and kill behaviour are identical in both builds.

Test Plan:
- Reset then ADD 0x0093, if_valid = 1, rf_rdata1 = 5, rf_rdata2 = 7 -> next cycle: ex_valid = 1, ex_exe_cmd = 0, ex_wb_en = 1, ex_src1 = 9, ex_src2 = 3, ex_val1 = 5, ex_val2 = 7.
- MOVI 0x6093 -> ex_is_imm = 1, ex_imm = 0x0093, ex_wb_en = 1. CMP 0x5093 -> ex_exe_cmd = 1, ex_wb_en = 0.
- BEQ 0x8004, pc_in = 0x0010, flagZ = 1 -> br_taken = 1, br_target = 0x0014. Following ADD -> ex_valid = 0 (killed). Same with flagZ = 0 -> br_taken = 0, next ADD valid.
- LDR 0xC210 (dest r2), then ADD 0x0123 (src1 = r2) -> id_stall = 1 for one cycle, one bubble (ex_valid = 0), then ADD issues. Without ID_LOAD_USE_DETECT_EN: no stall.
- ex_stall = 1 for 3 cycles while holding STR 0xD310 -> ex_* unchanged and id_stall = 1; on release, the next instruction loads. hazard_detected = 1 -> single bubble.
- rst asserted during a kill or a held stall -> next cycle all ex_* = 0, kill = 0, and the following instruction issues normally.
